// File: rtl/memtest_pkg.sv
// Shared types and constants for the memory tester's PLL frequency sequencer.
// Holds the sequencer FSM encoding, the step-index width and the MHz display lookup.
package memtest_pkg;

  localparam int unsigned StepW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StLwait,
    StBusyw,
    StRecfg,
    StSettle
  } pllseq_state_e;

  // Index 0 is the fastest step.
  function automatic logic [7:0] step_mhz(input logic [StepW-1:0] step);
    logic [7:0] mhz;
    case (step)
      4'd0:    mhz = 8'd167;
      4'd1:    mhz = 8'd160;
      4'd2:    mhz = 8'd150;
      4'd3:    mhz = 8'd140;
      4'd4:    mhz = 8'd130;
      4'd5:    mhz = 8'd120;
      4'd6:    mhz = 8'd110;
      4'd7:    mhz = 8'd100;
      4'd8:    mhz = 8'd90;
      4'd9:    mhz = 8'd80;
      4'd10:   mhz = 8'd70;
      default: mhz = 8'd0;
    endcase
    return mhz;
  endfunction

endpackage

// File: rtl/pllseq_edge.sv
// Rising-edge detector with a registered history bit; history clears on reset so a
// level held through reset produces exactly one edge afterwards.
module pllseq_edge (
  input  logic clk_i,
  input  logic reset_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/pll_freq_sequencer.sv
// Turns step requests into a committed step index and drives the pll_reconfig handshake.
// Define PLLSEQ_WATCHDOG_EN to enable the reconfig watchdog, cfg_reset and timeouts count.
module pll_freq_sequencer
  import memtest_pkg::*;
#(
  parameter int unsigned NUM_STEPS = 11,
  parameter int unsigned INIT_POS  = 7,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned SETTLE    = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_auto,
  input  logic             auto_start,
  input  logic             pass_seen,
  input  logic             fail_seen,
  input  logic             cfg_busy,
  input  logic             locked,
  output logic             cfg_write_from_rom,
  output logic             cfg_reconfig,
  output logic             cfg_reset,
  output logic [StepW-1:0] pos,
  output logic             auto_mode,
  output logic             recfg,
  output logic [7:0]       timeouts
);

  localparam logic [StepW-1:0] MaxStep  = StepW'(NUM_STEPS - 1);
  localparam logic [StepW-1:0] InitStep = StepW'(INIT_POS);
  localparam int unsigned      SetW     = $clog2(SETTLE + 1);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("SETTLE must be at least 1");
  end

  logic up_rise, down_rise, auto_rise;

  pllseq_edge u_edge_up   (.clk_i(clk), .reset_i(reset), .level_i(btn_up),   .rise_o(up_rise));
  pllseq_edge u_edge_down (.clk_i(clk), .reset_i(reset), .level_i(btn_down), .rise_o(down_rise));
  pllseq_edge u_edge_auto (.clk_i(clk), .reset_i(reset), .level_i(btn_auto), .rise_o(auto_rise));

  pllseq_state_e    state_q, state_d;
  logic [StepW-1:0] target_q, target_d, pos_q, pos_d;
  logic             pending_q, pending_d, auto_q, auto_d, recfg_q, recfg_d;
  logic             wr_q, wr_d, rc_q, rc_d;
  logic [SetW-1:0]  settle_q, settle_d;
  logic             accept;

`ifdef PLLSEQ_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           crst_q, crst_d;
  logic [7:0]     tmo_q, tmo_d;
`endif

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    pos_d     = pos_q;
    pending_d = pending_q;
    auto_d    = auto_q;
    recfg_d   = recfg_q;
    settle_d  = settle_q;
    wr_d      = 1'b0;
    rc_d      = 1'b0;
    accept    = 1'b0;
`ifdef PLLSEQ_WATCHDOG_EN
    wd_d      = wd_q;
    crst_d    = 1'b0;
    tmo_d     = tmo_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          pending_d = 1'b0;
          pos_d     = target_q;
          wr_d      = 1'b1;
          state_d   = StLoad;
        end
      end
      StLoad:  state_d = StLwait;
      StLwait: state_d = StBusyw;
      StBusyw: begin
        if (!cfg_busy) begin
          rc_d    = 1'b1;
          state_d = StRecfg;
`ifdef PLLSEQ_WATCHDOG_EN
          wd_d    = WdW'(TIMEOUT);
`endif
        end
      end
      StRecfg: begin
        // Busy is only trusted once the reconfig pulse has been seen by pll_reconfig.
`ifdef PLLSEQ_WATCHDOG_EN
        wd_d = wd_q - WdW'(1);
        if (!rc_q && !cfg_busy) begin
          settle_d = '0;
          state_d  = StSettle;
        end else if (wd_q == WdW'(1)) begin
          crst_d   = 1'b1;
          tmo_d    = (tmo_q == 8'hff) ? tmo_q : tmo_q + 8'd1;
          settle_d = '0;
          state_d  = StSettle;
        end
`else
        if (!rc_q && !cfg_busy) begin
          settle_d = '0;
          state_d  = StSettle;
        end
`endif
      end
      StSettle: begin
        if (!locked) begin
          settle_d = '0;
        end else if (settle_q == SetW'(SETTLE - 1)) begin
          state_d = StIdle;
          recfg_d = pending_q;
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (auto_start) begin
      target_d = '0;
      auto_d   = 1'b1;
      accept   = 1'b1;
    end else if (auto_rise) begin
      if (auto_q) begin
        auto_d = 1'b0;
      end else begin
        target_d = '0;
        auto_d   = 1'b1;
      end
      accept = 1'b1;
    end else if (down_rise && target_q < MaxStep) begin
      target_d = target_q + StepW'(1);
      auto_d   = 1'b0;
      accept   = 1'b1;
    end else if (up_rise && target_q != '0) begin
      target_d = target_q - StepW'(1);
      auto_d   = 1'b0;
      accept   = 1'b1;
    end else if (auto_q && pass_seen && fail_seen && state_q == StIdle && target_q < MaxStep) begin
      target_d = target_q + StepW'(1);
      accept   = 1'b1;
    end

    if (accept) begin
      pending_d = 1'b1;
      recfg_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      target_q  <= InitStep;
      pos_q     <= InitStep;
      pending_q <= 1'b0;
      auto_q    <= 1'b0;
      recfg_q   <= 1'b0;
      settle_q  <= '0;
      wr_q      <= 1'b0;
      rc_q      <= 1'b0;
`ifdef PLLSEQ_WATCHDOG_EN
      wd_q      <= '0;
      crst_q    <= 1'b0;
      tmo_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      pos_q     <= pos_d;
      pending_q <= pending_d;
      auto_q    <= auto_d;
      recfg_q   <= recfg_d;
      settle_q  <= settle_d;
      wr_q      <= wr_d;
      rc_q      <= rc_d;
`ifdef PLLSEQ_WATCHDOG_EN
      wd_q      <= wd_d;
      crst_q    <= crst_d;
      tmo_q     <= tmo_d;
`endif
    end
  end

  assign cfg_write_from_rom = wr_q;
  assign cfg_reconfig       = rc_q;
  assign pos                = pos_q;
  assign auto_mode          = auto_q;
  assign recfg              = recfg_q;
`ifdef PLLSEQ_WATCHDOG_EN
  assign cfg_reset          = crst_q;
  assign timeouts           = tmo_q;
`else
  assign cfg_reset          = 1'b0;
  assign timeouts           = 8'd0;
`endif

endmodule

// File: tb/tb_pll_freq_sequencer.sv
// Directed bench for pll_freq_sequencer with SETTLE=16 and TIMEOUT=1000.
module tb_pll_freq_sequencer;

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, btn_auto, auto_start, pass_seen, fail_seen;
  logic       cfg_busy, locked;
  logic       cfg_write_from_rom, cfg_reconfig, cfg_reset, auto_mode, recfg;
  logic [3:0] pos;
  logic [7:0] timeouts;

  int n_vec = 0;
  int n_err = 0;
  int n_wr = 0, n_rc = 0, n_crst = 0;

  pll_freq_sequencer #(
    .NUM_STEPS(11),
    .INIT_POS (7),
    .TIMEOUT  (1000),
    .SETTLE   (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .btn_up            (btn_up),
    .btn_down          (btn_down),
    .btn_auto          (btn_auto),
    .auto_start        (auto_start),
    .pass_seen         (pass_seen),
    .fail_seen         (fail_seen),
    .cfg_busy          (cfg_busy),
    .locked            (locked),
    .cfg_write_from_rom(cfg_write_from_rom),
    .cfg_reconfig      (cfg_reconfig),
    .cfg_reset         (cfg_reset),
    .pos               (pos),
    .auto_mode         (auto_mode),
    .recfg             (recfg),
    .timeouts          (timeouts)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_write_from_rom) n_wr++;
    if (cfg_reconfig) n_rc++;
    if (cfg_reset) n_crst++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0=up 1=down 2=auto button 3=auto_start; held for exactly one sampling edge.
  task automatic press(input int which);
    case (which)
      0:       btn_up = 1'b1;
      1:       btn_down = 1'b1;
      2:       btn_auto = 1'b1;
      default: auto_start = 1'b1;
    endcase
    tick();
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_auto = 1'b0;
    auto_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (recfg && n < 300) begin
      tick();
      n++;
    end
    check(tag, recfg, 0);
  endtask

  task automatic wait_rc(input string tag);
    int n = 0;
    while (!cfg_reconfig && n < 40) begin
      tick();
      n++;
    end
    check(tag, cfg_reconfig, 1);
  endtask

  initial begin
    int wr0, rc0, n;
    logic dropped;
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; btn_auto = 1'b0; auto_start = 1'b0;
    pass_seen = 1'b0; fail_seen = 1'b0; cfg_busy = 1'b0; locked = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_pos", pos, 7);
    check("rst_recfg", recfg, 0);
    check("rst_auto", auto_mode, 0);
    check("rst_timeouts", timeouts, 0);
    check("rst_pulses", n_wr + n_rc + n_crst, 0);

    // Up request: 7 -> 6, one ROM load and one reconfig.
    wr0 = n_wr; rc0 = n_rc;
    press(0);
    check("up_recfg_n1", recfg, 1);
    check("up_pos_n1", pos, 7);
    tick();
    check("up_wr_n2", cfg_write_from_rom, 1);
    check("up_pos_n2", pos, 6);
    wait_done("up_done");
    check("up_wr_cnt", n_wr - wr0, 1);
    check("up_rc_cnt", n_rc - rc0, 1);

    // auto_start beats a simultaneous up edge; locked drops mid-settle.
    btn_up = 1'b1;
    press(3);
    check("as_auto", auto_mode, 1);
    tick();
    check("as_pos", pos, 0);
    wait_rc("as_rc");
    repeat (2) tick();
    repeat (8) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    repeat (15) tick();
    check("relock_recfg_hold", recfg, 1);
    tick();
    check("relock_recfg_fall", recfg, 0);

    // Up at step 0 is ignored.
    wr0 = n_wr;
    press(0);
    repeat (4) tick();
    check("up0_recfg", recfg, 0);
    check("up0_wr", n_wr - wr0, 0);
    check("up0_pos", pos, 0);

    // Auto sweep 0 -> 10.
    for (int i = 1; i <= 10; i++) begin
      pass_seen = 1'b1; fail_seen = 1'b1;
      tick();
      pass_seen = 1'b0; fail_seen = 1'b0;
      wait_done("sweep_done");
      check("sweep_pos", pos, i);
    end
    pass_seen = 1'b1; fail_seen = 1'b1;
    tick();
    pass_seen = 1'b0; fail_seen = 1'b0;
    tick();
    check("sweep_stop_recfg", recfg, 0);
    check("sweep_stop_auto", auto_mode, 1);

    // Down at step 10 is ignored and leaves auto mode alone.
    wr0 = n_wr;
    press(1);
    repeat (4) tick();
    check("dn10_recfg", recfg, 0);
    check("dn10_wr", n_wr - wr0, 0);
    check("dn10_auto", auto_mode, 1);

    // Auto button while sweeping: leave auto mode, reload the same step.
    wr0 = n_wr;
    press(2);
    check("ab_recfg", recfg, 1);
    check("ab_auto", auto_mode, 0);
    wait_done("ab_done");
    check("ab_pos", pos, 10);
    check("ab_wr", n_wr - wr0, 1);

    press(0);
    wait_done("up9_done");
    check("up9_pos", pos, 9);

    // Down during RECFG: first sequence finishes at 8, second loads 9 back-to-back.
    wr0 = n_wr;
    press(0);
    wait_rc("mid_rc");
    cfg_busy = 1'b1;
    repeat (2) tick();
    press(1);
    check("mid_pos_old", pos, 8);
    cfg_busy = 1'b0;
    dropped = 1'b0;
    n = 0;
    while (n_wr - wr0 < 2 && n < 100) begin
      tick();
      if (!recfg) dropped = 1'b1;
      n++;
    end
    check("mid_second_load", n_wr - wr0, 2);
    check("mid_pos_new", pos, 9);
    check("mid_recfg_held", dropped, 0);
    wait_done("mid_done");
    check("mid_pos_final", pos, 9);

    // Watchdog: busy never clears after the reconfig pulse.
    press(1);
    wait_rc("wd_rc");
    cfg_busy = 1'b1;
    n = 0;
`ifdef PLLSEQ_WATCHDOG_EN
    while (!cfg_reset && n < 1100) begin
      tick();
      n++;
    end
    check("wd_delay", n, 1000);
    check("wd_crst_cnt", n_crst, 1);
    check("wd_timeouts", timeouts, 1);
`else
    repeat (1100) tick();
    check("wd_no_crst", n_crst, 0);
    check("wd_stuck", recfg, 1);
    check("wd_timeouts", timeouts, 0);
`endif
    cfg_busy = 1'b0;
    wait_done("wd_done");
    check("wd_pos", pos, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
